aes_word_sequencer: RTL and testbench
=====================================

Name: aes_word_sequencer

Overview:
- Front/back-end stage wrapped around aes_cipher_top.
- Accepts 32-bit words on a valid/ready stream and assembles the 128-bit key and 128-bit plaintext.
- Drives the core's ld/key/text_in, waits for done, captures text_out, and streams the ciphertext back as four 32-bit words on a second valid/ready stream.
- Adds a done-timeout watchdog with a sticky error flag.

Parameters:
TIMEOUT, 64, max cycles in BUSY waiting for done edge before abort (1..65535)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 resets at next rising clk)
in_valid  input  1  input word valid
in_ready  output  1  input word accepted when in_valid&&in_ready
in_key  input  1  1: word is key material; 0: word is plaintext
in_data  input  32  input word; first word of a group = bits [127:96]
out_valid  output  1  ciphertext word valid
out_ready  input  1  downstream accepts word
out_data  output  32  ciphertext word; first = bits [127:96]
out_last  output  1  high with 4th ciphertext word
core_ld  output  1  to aes_cipher_top ld; one-cycle pulse
core_key  output  128  to aes_cipher_top key
core_text_in  output  128  to aes_cipher_top text_in
core_done  input  1  from aes_cipher_top done
core_text_out  input  128  from aes_cipher_top text_out
key_valid  output  1  a full 128-bit key has been committed
err  output  1  sticky: timeout occurred; cleared only by reset

Behaviour:
- Reset (rst==0 at edge): state=LOAD; all counters 0; core_key, core_text_in, out buffer = 0; core_ld, out_valid, out_last, key_valid, err = 0; done_q=0. Reset mid-operation aborts everything, including a partially assembled key or text.
- States: LOAD, LAUNCH, BUSY, DRAIN.
- LOAD:
  - in_ready = 1, except in_ready = 0 when in_key==0 && txt_cnt==3 && key_valid==0. The 4th text word is never accepted without a key.
  - Key word accepted: shift into key_shadow; kcnt++. On the 4th word, commit key_shadow to core_key, set key_valid, kcnt wraps to 0.
  - Text word accepted: shift into core_text_in; txt_cnt++. On the 4th word, txt_cnt wraps to 0 and next state = LAUNCH.
  - Partial key groups never alter core_key. A new key may be loaded between blocks and persists across blocks.
- LAUNCH: core_ld=1 for exactly this one cycle; in_ready=0. Next state = BUSY; clear timeout counter.
- BUSY:
  - in_ready=0; core_key and core_text_in held stable.
  - done_q <= core_done every cycle. Completion = core_done && !done_q (rising edge); a level-high done left over from a prior block is ignored.
  - On completion: capture core_text_out into out buffer, word index=0, next state DRAIN.
  - Otherwise the counter increments. When it reaches TIMEOUT: set err, next state LOAD, nothing emitted.
  - If completion and timeout coincide in the same cycle, completion wins.
- DRAIN:
  - out_valid=1. out_data = buffer word[idx], idx 0 → bits [127:96].
  - out_data and out_last are stable while out_valid && !out_ready.
  - On handshake idx++. out_last=1 when idx==3. Handshake on idx 3 → LOAD with out_valid=0.
  - in_ready=0 throughout DRAIN.
- Latency:
  - The 4th text word accept edge produces core_ld high in the next cycle.
  - The edge sampling the done rising edge produces out_valid high in the next cycle.
  - With out_ready held high, the 4 words occupy 4 consecutive cycles.
- Zero-bubble back-to-back operation is not required. LOAD is re-entered for at least 1 cycle after DRAIN.

Test Plan:
1. Reset, then load key words 00010203,04050607,08090a0b,0c0d0e0f and text 00112233,44556677,8899aabb,ccddeeff with out_ready=1 → core_ld exactly one cycle. Output 69c4e0d8,6a7b0430,d8cdb780,70b4c55a with out_last on the 4th word; err=0.
2. Text words before any key (key_valid=0) → first 3 text words accepted; in_ready=0 on the 4th. Send the key → key_valid=1, the 4th text word is accepted, and the block completes correctly.
3. Key cafebabe,deadbeef,deadbeef,00000000; text all zero; out_ready toggled 1/0 each cycle → each output word held stable while not accepted; sequence equals core_text_out split MSW-first.
4. Stub core with done stuck low, TIMEOUT=64 → err=1 after 64 BUSY cycles; return to LOAD; no out_valid; err stays high through the next good block.
5. Second block reusing the stored key, with core done still high from the previous block at LAUNCH → no premature capture; result taken only on the new done rising edge.
6. Drive rst=0 for one cycle during BUSY, and again during DRAIN at idx 2 → all outputs return to reset values; key_valid=0; a following full sequence completes correctly.

Source files
------------

// File: rtl/aes_word_sequencer.sv
// aes_word_sequencer: 32-bit word front/back end around aes_cipher_top.
// Assembles a 128-bit key and plaintext from an input word stream, launches the
// core, waits for a rising edge on done with a watchdog, and streams the
// 128-bit result back as four words, most significant word first.
module aes_word_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_key,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         core_ld,
  output logic [127:0] core_key,
  output logic [127:0] core_text_in,
  input  logic         core_done,
  input  logic [127:0] core_text_out,
  output logic         key_valid,
  output logic         err
);

  localparam int unsigned WW = 32;
  localparam int unsigned BW = 128;
  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [BW-1:0] key_shadow;
  logic [BW-1:0] out_buf;
  logic [1:0]    kcnt, txt_cnt, idx;
  logic [TW-1:0] tmo_cnt;
  logic          done_q;

  logic ready_c, key_acc_c, txt_acc_c, out_acc_c, done_rise_c, tmo_hit_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_LOAD;
    else      state <= state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    state_nxt   = state;
    ready_c     = 1'b0;
    key_acc_c   = 1'b0;
    txt_acc_c   = 1'b0;
    out_acc_c   = 1'b0;
    done_rise_c = core_done && !done_q;
    tmo_hit_c   = (tmo_cnt + TW'(1)) == TMO_MAX;
    case (state)
      ST_LOAD: begin
        // The final text word waits until a full key exists.
        ready_c   = !(!in_key && (txt_cnt == 2'd3) && !key_valid);
        key_acc_c = in_valid && ready_c && in_key;
        txt_acc_c = in_valid && ready_c && !in_key;
        if (txt_acc_c && (txt_cnt == 2'd3)) state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: state_nxt = ST_BUSY;
      ST_BUSY: begin
        // Completion takes priority over a coincident timeout.
        if (done_rise_c)    state_nxt = ST_DRAIN;
        else if (tmo_hit_c) state_nxt = ST_LOAD;
      end
      ST_DRAIN: begin
        out_acc_c = out_valid && out_ready;
        if (out_acc_c && (idx == 2'd3)) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  assign in_ready = ready_c;
  assign out_data = out_buf[BW-1 -: WW];
  assign out_last = out_valid && (idx == 2'd3);

  // Datapath: word assembly, launch strobe, watchdog, output buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_shadow   <= '0;
      core_key     <= '0;
      core_text_in <= '0;
      out_buf      <= '0;
      kcnt         <= '0;
      txt_cnt      <= '0;
      idx          <= '0;
      tmo_cnt      <= '0;
      done_q       <= 1'b0;
      core_ld      <= 1'b0;
      out_valid    <= 1'b0;
      key_valid    <= 1'b0;
      err          <= 1'b0;
    end else begin
      done_q  <= core_done;
      core_ld <= 1'b0;

      if (key_acc_c) begin
        key_shadow <= {key_shadow[BW-WW-1:0], in_data};
        kcnt       <= kcnt + 2'd1;
        if (kcnt == 2'd3) begin
          core_key  <= {key_shadow[BW-WW-1:0], in_data};
          key_valid <= 1'b1;
        end
      end

      if (txt_acc_c) begin
        core_text_in <= {core_text_in[BW-WW-1:0], in_data};
        txt_cnt      <= txt_cnt + 2'd1;
        if (txt_cnt == 2'd3) core_ld <= 1'b1;
      end

      if (state == ST_LAUNCH) tmo_cnt <= '0;

      if (state == ST_BUSY) begin
        if (done_rise_c) begin
          out_buf   <= core_text_out;
          idx       <= 2'd0;
          out_valid <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
          if (tmo_hit_c) err <= 1'b1;
        end
      end

      if (out_acc_c) begin
        out_buf <= {out_buf[BW-WW-1:0], WW'(0)};
        idx     <= idx + 2'd1;
        if (idx == 2'd3) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_word_sequencer.sv
// Bench for aes_word_sequencer with a behavioural stand-in for aes_cipher_top.
`timescale 1ns/1ps
module tb_aes_word_sequencer;

  localparam int unsigned TMO = 64;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_key = 1'b0;
  logic [31:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         out_last;
  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text_in;
  logic         core_done = 1'b0;
  logic [127:0] core_text_out = '0;
  logic         key_valid;
  logic         err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_word_sequencer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
    .core_done(core_done), .core_text_out(core_text_out),
    .key_valid(key_valid), .err(err)
  );

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Stand-in cipher: the FIPS-197 vector maps to its known ciphertext, anything
  // else to a simple keyed mix so every block has a distinct, predictable answer.
  function automatic logic [127:0] cipher_ref(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
    return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;
  endfunction

  // Core stub controls
  int unsigned  lat = 6;
  bit           stuck = 0;
  bit           sticky = 0;
  bit           stub_clr = 0;
  int unsigned  scnt = 0;
  logic [127:0] stub_k = '0, stub_t = '0;
  logic         ld_s = 1'b0;
  logic [127:0] key_s = '0, txt_s = '0;

  always @(negedge clk) begin
    ld_s  <= core_ld;
    key_s <= core_key;
    txt_s <= core_text_in;
  end

  always @(posedge clk) begin
    if (stub_clr) begin
      scnt      <= 0;
      core_done <= 1'b0;
    end else if (ld_s) begin
      stub_k        <= key_s;
      stub_t        <= txt_s;
      scnt          <= lat;
      core_text_out <= {$urandom, $urandom, $urandom, $urandom};
    end else if (scnt != 0) begin
      scnt <= scnt - 1;
      if (scnt == 2) core_done <= 1'b0;
      if (scnt == 1 && !stuck) begin
        core_done     <= 1'b1;
        core_text_out <= cipher_ref(stub_k, stub_t);
      end
    end else if (!sticky) begin
      core_done <= 1'b0;
    end
  end

  // Reference model state
  logic [127:0] mk_sh = '0, mk = '0, mt = '0;
  bit           mkv = 0;
  int           kc = 0, tc = 0;
  logic [127:0] exp_ld_key = '0, exp_ld_txt = '0;
  int           launches = 0, ld_seen = 0;
  logic [32:0]  expq[$];

  function automatic void model_accept(input logic k, input logic [31:0] d);
    logic [127:0] res;
    if (k) begin
      mk_sh = {mk_sh[95:0], d};
      kc++;
      if (kc == 4) begin
        kc  = 0;
        mk  = mk_sh;
        mkv = 1;
      end
      chk("key_valid", 128'(key_valid), 128'(mkv));
    end else begin
      mt = {mt[95:0], d};
      tc++;
      if (tc == 4) begin
        tc = 0;
        exp_ld_key = mk;
        exp_ld_txt = mt;
        launches++;
        chk("ld_latency", 128'(core_ld), 1);
        if (!stuck) begin
          res = cipher_ref(mk, mt);
          for (int i = 0; i < 4; i++)
            expq.push_back({(i == 3), res[127 - 32*i -: 32]});
        end
      end
    end
  endfunction

  task automatic send(input logic k, input logic [31:0] d, input int maxw, output bit ok);
    int n;
    n  = 0;
    ok = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_key   = k;
    in_data  = d;
    #1;
    while (!in_ready && n < maxw) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (in_ready) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      ok = 1;
      model_accept(k, d);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic send_blk(input logic k, input logic [127:0] v);
    bit ok;
    for (int i = 0; i < 4; i++) begin
      send(k, v[127 - 32*i -: 32], 50, ok);
      chk(k ? "key_word_accept" : "txt_word_accept", 128'(ok), 1);
    end
  endtask

  task automatic wait_empty(input string nm, input int maxc);
    int n;
    n = 0;
    while (expq.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 128'(expq.size()), 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_key   = 1'b0;
    stub_clr = 1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 0);
    chk("rst_out_last",  128'(out_last), 0);
    chk("rst_core_ld",   128'(core_ld), 0);
    chk("rst_key_valid", 128'(key_valid), 0);
    chk("rst_err",       128'(err), 0);
    chk("rst_in_ready",  128'(in_ready), 1);
    chk("rst_core_key",  core_key, 0);
    chk("rst_core_text", core_text_in, 0);
    chk("rst_out_data",  128'(out_data), 0);
    @(negedge clk);
    rst      = 1'b1;
    stub_clr = 0;
    expq.delete();
    kc = 0; tc = 0; mkv = 0;
    mk_sh = '0; mk = '0; mt = '0;
  endtask

  // out_ready pattern: 0 manual, 1 high, 2 toggle, 3 random
  int rdy_mode = 1;
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      1: out_ready = 1'b1;
      2: out_ready = ~out_ready;
      3: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Output monitor / scoreboard
  bit          held = 0, pv = 0, prev_ld = 0;
  logic        dh1 = 1'b0, dh2 = 1'b0;
  logic [31:0] hd = '0;
  logic        hl = 1'b0;
  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (!rst) begin
      held = 0; pv = 0; prev_ld = 0;
    end else begin
      if (core_ld) begin
        chk("ld_pulse_width", 128'(prev_ld), 0);
        chk("ld_key",  core_key, exp_ld_key);
        chk("ld_text", core_text_in, exp_ld_txt);
        ld_seen++;
      end
      if (out_valid && !pv)
        chk("capture_on_done_edge", 128'({dh2, dh1}), 128'(2'b01));
      if (held && out_valid) begin
        chk("hold_data", 128'(out_data), 128'(hd));
        chk("hold_last", 128'(out_last), 128'(hl));
      end
      if (out_valid && out_ready) begin
        chk("out_expected", 128'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("out_data", 128'(out_data), 128'(e[31:0]));
          chk("out_last", 128'(out_last), 128'(e[32]));
        end
      end
      held    = out_valid && !out_ready;
      hd      = out_data;
      hl      = out_last;
      pv      = out_valid;
      prev_ld = core_ld;
    end
    dh2 = dh1;
    dh1 = core_done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    repeat (3) @(negedge clk);
    do_reset();

    // Known vector, out_ready high
    lat = 10;
    send_blk(1'b1, FIPS_KEY);
    send_blk(1'b0, FIPS_PT);
    wait_empty("fips_drain", 200);
    chk("fips_err", 128'(err), 0);

    // Text before key: fourth word stalls until a key is committed
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(1'b0, $urandom, 50, ok);
      chk("early_txt_accept", 128'(ok), 1);
    end
    send(1'b0, 32'h1234_5678, 6, ok);
    chk("txt4_stalled_no_key", 128'(ok), 0);
    send_blk(1'b1, {$urandom, $urandom, $urandom, $urandom});
    chk("key_valid_after_key", 128'(key_valid), 1);
    send(1'b0, 32'h1234_5678, 50, ok);
    chk("txt4_accept_with_key", 128'(ok), 1);
    wait_empty("nokey_drain", 200);

    // Backpressure: out_ready toggles every cycle
    rdy_mode = 2;
    send_blk(1'b1, 128'hcafebabe_deadbeef_deadbeef_00000000);
    send_blk(1'b0, 128'h0);
    wait_empty("toggle_drain", 300);
    rdy_mode = 1;

    // Done stuck low: watchdog fires, nothing emitted
    stuck = 1;
    send_blk(1'b0, {$urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (!err && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 128'(n), 128'(TMO + 2));
    chk("timeout_back_to_load", 128'(in_ready), 1);
    chk("timeout_no_output", 128'(out_valid), 0);
    stuck = 0;
    send_blk(1'b0, {$urandom, $urandom, $urandom, $urandom});
    wait_empty("post_timeout_drain", 200);
    chk("err_sticky", 128'(err), 1);

    // Done left high across LAUNCH: only a fresh rising edge captures
    sticky = 1;
    lat = 8;
    for (int b = 0; b < 2; b++) begin
      send_blk(1'b0, {$urandom, $urandom, $urandom, $urandom});
      wait_empty("sticky_done_drain", 200);
    end
    sticky = 0;

    // Reset during BUSY
    lat = 20;
    send_blk(1'b0, {$urandom, $urandom, $urandom, $urandom});
    repeat (3) @(negedge clk);
    do_reset();

    // Reset during DRAIN with idx at 2
    lat = 6;
    rdy_mode = 0;
    out_ready = 1'b0;
    send_blk(1'b1, {$urandom, $urandom, $urandom, $urandom});
    send_blk(1'b0, {$urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_reached", 128'(out_valid), 1);
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 out_ready = 1'b0;
    @(negedge clk);
    chk("drain_idx2_pending", 128'(expq.size()), 2);
    if (expq.size() == 2) chk("drain_idx2_word", 128'(out_data), 128'(expq[0][31:0]));
    do_reset();
    rdy_mode = 1;
    send_blk(1'b1, FIPS_KEY);
    send_blk(1'b0, FIPS_PT);
    wait_empty("post_reset_drain", 200);

    // Randomized blocks
    for (int b = 0; b < 8; b++) begin
      lat = $urandom_range(3, 12);
      rdy_mode = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) send_blk(1'b1, {$urandom, $urandom, $urandom, $urandom});
      send_blk(1'b0, {$urandom, $urandom, $urandom, $urandom});
      wait_empty("random_drain", 400);
    end
    rdy_mode = 1;
    repeat (4) @(negedge clk);
    chk("ld_count", 128'(ld_seen), 128'(launches));
    chk("final_err", 128'(err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
